aes_lite_dec: RTL and testbench

AES_LITE_DEC -- requirements
Module: aes_lite_dec

---
 rtl/aes_lite_pkg.sv | 32 +++
 rtl/aes_lite_inv_sbox4.sv | 11 +
 rtl/aes_lite_dec.sv | 82 ++++++++
 tb/tb_aes_lite_dec.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/aes_lite_pkg.sv
// Shared definitions for the 8-bit lite cipher: round count, S-box tables,
// round-key schedule and controller state encodings.
package aes_lite_pkg;

  localparam int DEF_NUM_ROUNDS = 4;

  // Nibble tables packed low-index-first: entry i lives at bits [4*i +: 4].
  localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] INV_SBOX = 64'hA970364BD21C8FE5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ROUND = 2'd1;
  localparam state_t ST_FINAL = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  function automatic logic [3:0] sbox4(input logic [3:0] din);
    return SBOX[{din, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox4(input logic [3:0] din);
    return INV_SBOX[{din, 2'b00} +: 4];
  endfunction

  // Kr = rotl(key, r mod 8) ^ {4'h0, r}; r = 0 yields the raw key.
  function automatic logic [7:0] round_key(input logic [7:0] key, input logic [3:0] r);
    logic [15:0] dbl;
    dbl = {key, key} << r[2:0];
    return dbl[15:8] ^ {4'h0, r};
  endfunction

endpackage

// File: rtl/aes_lite_inv_sbox4.sv
// 4-bit combinational inverse S-box of the lite cipher.
module aes_lite_inv_sbox4
  import aes_lite_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = inv_sbox4(din);

endmodule

// File: rtl/aes_lite_dec.sv
// Iterative decryptor for the 8-bit lite cipher: one round per clock,
// followed by a final key whitening step.
module aes_lite_dec
  import aes_lite_pkg::*;
#(
  parameter int NUM_ROUNDS = DEF_NUM_ROUNDS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] cipher_in,
  input  logic [7:0] key_in,
  output logic [7:0] plain_out,
  output logic       busy,
  output logic       done
);

  state_t      state;
  logic [3:0]  rnd;
  logic [7:0]  s;
  logic [7:0]  key_r;
  logic [7:0]  rk;
  logic [7:0]  mixed;
  logic [7:0]  rotated;
  logic [7:0]  s_next;

  // Round r inverse: s = INV_SBOX(rotr1(s ^ Kr)).
  always_comb begin
    rk      = round_key(key_r, rnd);
    mixed   = s ^ rk;
    rotated = {mixed[0], mixed[7:1]};
  end

  aes_lite_inv_sbox4 u_inv_hi (
    .din  (rotated[7:4]),
    .dout (s_next[7:4])
  );

  aes_lite_inv_sbox4 u_inv_lo (
    .din  (rotated[3:0]),
    .dout (s_next[3:0])
  );

  // Working state is kept apart from plain_out so an aborted run never leaks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rnd       <= '0;
      s         <= '0;
      key_r     <= '0;
      plain_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            s     <= cipher_in;
            key_r <= key_in;
            rnd   <= 4'(NUM_ROUNDS);
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          s   <= s_next;
          rnd <= rnd - 4'd1;
          if (rnd == 4'd1) state <= ST_FINAL;
        end
        ST_FINAL: begin
          plain_out <= s ^ key_r;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_lite_dec.sv
// Directed bench for aes_lite_dec: latency, round trips, ignored start,
// mid-run reset, back-to-back requests and operand isolation.
module tb_aes_lite_dec;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] cipher_in;
  logic [7:0] key_in;
  logic [7:0] plain_out;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  aes_lite_dec #(.NUM_ROUNDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cipher_in (cipher_in),
    .key_in    (key_in),
    .plain_out (plain_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] tb_sb(input logic [3:0] v);
    case (v)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
    endcase
  endfunction

  function automatic logic [7:0] tb_rk(input logic [7:0] key, input int r);
    logic [7:0] t;
    t = key;
    for (int i = 0; i < r % 8; i++) t = {t[6:0], t[7]};
    return t ^ 8'(r & 15);
  endfunction

  function automatic logic [7:0] tb_enc(input logic [7:0] p, input logic [7:0] k);
    logic [7:0] st;
    st = p ^ k;
    for (int r = 1; r <= 4; r++) begin
      st = {tb_sb(st[7:4]), tb_sb(st[3:0])};
      st = {st[6:0], st[7]};
      st = st ^ tb_rk(k, r);
    end
    return st;
  endfunction

  // mode 0: plain request; 1: extra start with other operands in cycle 2;
  // 2: operands scrambled every cycle after capture.
  task automatic run(input logic [7:0] c, input logic [7:0] k, input int mode,
                     input logic [7:0] exp, input string tag);
    int lat;
    lat = 99;
    @(negedge clk);
    start = 1'b1; cipher_in = c; key_in = k;
    @(posedge clk); #1;
    check8({tag, "_busy_accept"}, {7'd0, busy}, 8'd1);
    check8({tag, "_done_accept"}, {7'd0, done}, 8'd0);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      start = (mode == 1 && cyc == 2);
      if (mode == 1 && cyc == 2) begin
        cipher_in = ~c; key_in = k ^ 8'h5A;
      end
      if (mode == 2) begin
        cipher_in = 8'($urandom); key_in = 8'($urandom);
      end
      @(posedge clk); #1;
      if (done) begin
        lat = cyc;
        break;
      end
    end
    start = 1'b0;
    check8({tag, "_latency"}, 8'(lat), 8'd5);
    check8({tag, "_plain"}, plain_out, exp);
    check8({tag, "_busy_done"}, {7'd0, busy}, 8'd0);
  endtask

  initial begin
    logic [7:0] p, k;
    rst_n = 1'b0; start = 1'b0; cipher_in = '0; key_in = '0;
    #1;
    check8("reset_plain", plain_out, 8'h00);
    check8("reset_busy", {7'd0, busy}, 8'd0);
    check8("reset_done", {7'd0, done}, 8'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    // Hand-computed vector: key 0 decrypts 0x72 to 0x00.
    run(8'h72, 8'h00, 0, 8'h00, "vec72");
    // Hold result across idle cycles.
    repeat (3) @(posedge clk);
    #1;
    check8("hold_plain", plain_out, 8'h00);
    check8("hold_done", {7'd0, done}, 8'd1);

    for (int i = 0; i < 256; i++) begin
      p = 8'($urandom); k = 8'($urandom);
      run(tb_enc(p, k), k, 0, p, "rt");
    end

    run(tb_enc(8'h3C, 8'hA5), 8'hA5, 1, 8'h3C, "ignore_start");

    // Abort at round 2 after a known non-zero result is on plain_out.
    @(negedge clk);
    start = 1'b1; cipher_in = tb_enc(8'h99, 8'h17); key_in = 8'h17;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check8("abort_plain", plain_out, 8'h00);
    check8("abort_busy", {7'd0, busy}, 8'd0);
    check8("abort_done", {7'd0, done}, 8'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    run(tb_enc(8'hE1, 8'h4D), 8'h4D, 0, 8'hE1, "after_abort");

    // Back-to-back from DONE: run() checks done falls on the accepting edge.
    run(tb_enc(8'h5B, 8'hC3), 8'hC3, 0, 8'h5B, "b2b");

    run(tb_enc(8'hFF, 8'hFF), 8'hFF, 2, 8'hFF, "toggle");
    run(tb_enc(8'h81, 8'h7E), 8'h7E, 2, 8'h81, "toggle2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
